// File: rtl/decoder_2to4.sv
// 2-to-4 one-hot decoder with active-high enable.
// The combinational `out` is the building block of a decoder tree. A parent's
// `out` feeds its children's `enable`, so `out` has no register and no reset.
// The registered `out_q`/`valid_q` give downstream select logic a glitch-free,
// clock-aligned copy.
module decoder_2to4 (
  input  logic       clk,
  input  logic       reset,    // asynchronous, active-low
  input  logic [1:0] in,
  input  logic       enable,
  output logic [3:0] out,
  output logic [3:0] out_q,
  output logic       valid_q
);

  logic [3:0] out_d;
  logic       valid_d;

  // Decode one output bit per select code. The enable is ANDed into every bit,
  // so an unknown select with enable low still produces 0000.
  always_comb begin
    // NOTE: assigning a default first means every path writes every bit, so no
    // latch can be inferred.
    out_d = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      out_d[k] = enable & (in == k[1:0]);
    end
  end

  assign out     = out_d;
  assign valid_d = enable;

  // Capture the decoded value and its enable on each rising clock edge.
  // Reset clears them at once, without waiting for an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q   <= 4'b0000;
      valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments give every register its pre-edge value,
      // so the order of statements cannot create a race.
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_decoder_2to4.sv
// Directed testbench for decoder_2to4. It also builds a 4-to-16 tree from
// five decoder instances to exercise the cascade use.
module tb_decoder_2to4;

  logic       clk;
  logic       reset;
  logic [1:0] sel;
  logic       en;
  logic [3:0] dec;
  logic [3:0] dec_q;
  logic       vld_q;

  int tests_run;
  int tests_failed;

  decoder_2to4 dut (
    .clk     (clk),
    .reset   (reset),
    .in      (sel),
    .enable  (en),
    .out     (dec),
    .out_q   (dec_q),
    .valid_q (vld_q)
  );

  // Cascade: the root decodes addr[3:2], and each leaf decodes addr[1:0].
  logic [3:0]  addr;
  logic        tree_en;
  logic [3:0]  root_out;
  logic [15:0] tree_out;
  logic [3:0]  root_q_unused;
  logic        root_v_unused;
  logic [15:0] leaf_q_unused;
  logic [3:0]  leaf_v_unused;

  decoder_2to4 u_root (
    .clk     (clk),
    .reset   (reset),
    .in      (addr[3:2]),
    .enable  (tree_en),
    .out     (root_out),
    .out_q   (root_q_unused),
    .valid_q (root_v_unused)
  );

  for (genvar g = 0; g < 4; g++) begin : g_leaf
    decoder_2to4 u_leaf (
      .clk     (clk),
      .reset   (reset),
      .in      (addr[1:0]),
      .enable  (root_out[g]),
      .out     (tree_out[4*g+3:4*g]),
      .out_q   (leaf_q_unused[4*g+3:4*g]),
      .valid_q (leaf_v_unused[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance one full cycle, so that inputs driven at a falling edge are
  // captured at the rising edge and then sampled at the next falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [3:0] exp_comb [8];
  logic [2:0] v;
  logic [4:0] w;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    exp_comb = '{4'b0000, 4'b0000, 4'b0000, 4'b0000,
                 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    reset   = 1'b0;
    sel     = 2'd0;
    en      = 1'b0;
    addr    = 4'd0;
    tree_en = 1'b0;

    #2;
    check("reset_out_q", {12'd0, dec_q}, 16'h0000);
    check("reset_valid_q", {15'd0, vld_q}, 16'h0000);

    // Exhaustive combinational sweep of {enable,in}, 10 time units per step.
    for (int i = 0; i < 8; i++) begin
      v = i[2:0];
      {en, sel} = v;
      #1;
      check($sformatf("comb_%0d", i), {12'd0, dec}, {12'd0, exp_comb[i]});
      #9;
    end

    // A clock edge while reset is held must not load the registers.
    @(negedge clk);
    en = 1'b1; sel = 2'd3;
    tick();
    check("held_reset_out_q", {12'd0, dec_q}, 16'h0000);
    check("held_reset_valid_q", {15'd0, vld_q}, 16'h0000);

    // Registered follow: in = 2, 3, 0 on consecutive cycles.
    reset = 1'b1;
    en = 1'b1; sel = 2'd2;
    tick();
    check("follow_2", {12'd0, dec_q}, 16'b0100);
    check("follow_2_valid", {15'd0, vld_q}, 16'h0001);
    sel = 2'd3;
    tick();
    check("follow_3", {12'd0, dec_q}, 16'b1000);
    sel = 2'd0;
    tick();
    check("follow_0", {12'd0, dec_q}, 16'b0001);
    check("follow_0_valid", {15'd0, vld_q}, 16'h0001);

    // Async reset mid-stream, asserted between clock edges.
    sel = 2'd3;
    tick();
    check("pre_reset_out_q", {12'd0, dec_q}, 16'b1000);
    #2 reset = 1'b0;
    #1;
    check("async_out_q", {12'd0, dec_q}, 16'h0000);
    check("async_valid_q", {15'd0, vld_q}, 16'h0000);
    check("async_comb_tracks", {12'd0, dec}, 16'b1000);
    @(negedge clk);
    en = 1'b1; sel = 2'd1;
    reset = 1'b1;
    tick();
    check("release_out_q", {12'd0, dec_q}, 16'b0010);
    check("release_valid_q", {15'd0, vld_q}, 16'h0001);

    // Enable low gates an unknown select.
    en = 1'b0; sel = 2'bxx;
    #1;
    check("x_gated_out", {12'd0, dec}, 16'h0000);
    @(negedge clk);
    tick();
    check("x_gated_out_q", {12'd0, dec_q}, 16'h0000);
    check("x_gated_valid_q", {15'd0, vld_q}, 16'h0000);
    sel = 2'd0;

    // Cascade sweep of {enable, addr} from 0 to 31.
    for (int i = 0; i < 32; i++) begin
      w = i[4:0];
      {tree_en, addr} = w;
      #1;
      check($sformatf("tree_%0d", i), tree_out,
            (i >= 16) ? (16'h0001 << (i - 16)) : 16'h0000);
      #4;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/decoder_2to4.md
# decoder_2to4

2-to-4 one-hot decoder with active-high enable and a registered copy of its output. The combinational output `out` is the leaf and root primitive of the decoder tree: four instances decode the low address bits and a fifth drives their enables from the high bits to form a 4-to-16 decoder. Because the tree cascades `out` into `enable`, `out` must stay purely combinational. The registered outputs give the note/key-select logic a glitch-free, clock-aligned version.

## Interface
- No parameters; widths fixed (2-bit select, 4-bit one-hot).
- `clk`  in  1  system clock; all registers update on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `in`  in  2  select code.
- `enable`  in  1  active-high decode enable.
- `out`  out  4  combinational one-hot decode: `out[in] = enable`, all other bits 0.
- `out_q`  out  4  `out` registered by one `clk` cycle.
- `valid_q`  out  1  `enable` registered by one `clk` cycle.

## Operation
- Combinational path, with no dependence on `clk` or `reset`:
  - `enable=1`: `out = 4'b0001 << in`, so in=0→0001, 1→0010, 2→0100, 3→1000.
  - `enable=0`: `out = 4'b0000` regardless of `in`.
- `out` is always one-hot or zero, never more than one bit set.
- Registered path:
  - on each rising `clk`: `out_q <= out`, `valid_q <= enable`.
  - invariant: `valid_q=0` implies `out_q=0000`, and `valid_q=1` implies `out_q` is exactly one-hot.
- X/Z on `in` while `enable=0`: `out` must still be 0000, so the enable gates every output bit.
- Tree use: the parent instance's `out` drives the children's `enable` inputs. There is no combinational loop, because `out` depends only on `in` and `enable`.

## Timing
- `out`: zero-cycle combinational latency from `in`/`enable`.
- `out_q`, `valid_q`: one-cycle latency; the value sampled at rising edge N is visible after edge N.
- Reset:
  - asynchronous assertion (`reset` falling to 0) immediately forces `out_q=0000` and `valid_q=0`, without waiting for a clock edge;
  - the registers hold those values while `reset=0`.
- Reset release: the first rising `clk` with `reset=1` captures the current `out`/`enable`.
- Reset mid-operation: the registered outputs clear at once; `out` keeps tracking its inputs, because reset does not gate the combinational path.
- Simultaneous input change and clock edge: the register captures the pre-edge settled value (standard setup/hold).

## Test plan
- Exhaustive combinational sweep of `{enable,in}` from 0 to 7, 10 time units per step:
  - 0–3 → `out=0000`;
  - 4→0001, 5→0010, 6→0100, 7→1000.
- Registered follow: reset released, then apply `enable=1` with `in`=2, then 3, then 0 on consecutive cycles → `out_q` = 0100, 1000, 0001, each one cycle after its input, with `valid_q=1`.
- Async reset mid-stream: with `out_q=1000`, drive `reset=0` between clock edges → `out_q=0000` and `valid_q=0` immediately. Release `reset` with `enable=1`, `in=1` → `out_q=0010` after the next edge.
- Enable gating with X: `enable=0`, `in=2'bx` → `out=0000`, and `out_q=0000` after the next edge.
- Cascade: build the 4-to-16 tree from five instances and sweep `{enable,in[3:0]}` from 0 to 31 → the 16-bit output is 0 for values 0–15 and equals `1<<in` for 16–31, so every output bit is asserted exactly once.
